// File: rtl/alu_op_sequencer.sv
// Expands (opcode, operand) pairs into per-cycle control words for the 8-bit adder/accumulator datapath.
// Define SEQ_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front of the sequencer; otherwise a single holding register is used.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] opcode,
    input  logic [7:0] operand,
    output logic [7:0] bus_data,
    output logic       nLa,
    output logic       nLb,
    output logic       Ea,
    output logic       Eu,
    output logic       sub,
    output logic       out_sel,
    input  logic       cf_in,
    input  logic       zf_in,
    output logic       cf_q,
    output logic       zf_q,
    output logic       done,
    output logic       err,
    output logic [7:0] op_count
);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two in 2..8");
    end

    typedef enum logic [1:0] {IDLE, EX1, EX2, FLG} state_t;

    state_t     state;
    logic [2:0] cur_op;
    logic       take;
    logic [2:0] take_op;
    logic [7:0] take_data;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

`ifdef SEQ_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [10:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;

    assign op_ready = !rst && (count != FULL_CNT);
    assign push     = op_valid && op_ready;
    assign take     = (state == IDLE) && (count != '0);
    assign {take_op, take_data} = mem[rd_ptr];

    // FIFO storage carries no reset; occupancy is tracked by count alone
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {opcode, operand};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (take) rd_ptr <= rd_ptr + 1'b1;
            case ({push, take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
`else
    // Transfer and dequeue coincide: the pair goes straight into cur_op/bus_data
    assign op_ready  = !rst && (state == IDLE);
    assign take      = op_valid && op_ready;
    assign take_op   = opcode;
    assign take_data = operand;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_op   <= OP_NOP;
            bus_data <= 8'h00;
            nLa      <= 1'b1;
            nLb      <= 1'b1;
            Ea       <= 1'b0;
            Eu       <= 1'b0;
            sub      <= 1'b0;
            out_sel  <= 1'b0;
            cf_q     <= 1'b0;
            zf_q     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_count <= 8'h00;
        end else begin
            nLa     <= 1'b1;
            nLb     <= 1'b1;
            Ea      <= 1'b0;
            Eu      <= 1'b0;
            sub     <= 1'b0;
            out_sel <= 1'b0;
            done    <= 1'b0;
            // Outputs are loaded with the control word of the state being entered
            case (state)
                IDLE: begin
                    if (take) begin
                        cur_op <= take_op;
                        case (take_op)
                            OP_LDA: begin
                                bus_data <= take_data;
                                nLa      <= 1'b0;
                                state    <= EX1;
                            end
                            OP_ADD, OP_SUB: begin
                                bus_data <= take_data;
                                nLb      <= 1'b0;
                                state    <= EX1;
                            end
                            OP_OUT: begin
                                Ea      <= 1'b1;
                                out_sel <= 1'b1;
                                state   <= EX1;
                            end
                            OP_NOP: begin
                                done  <= 1'b1;
                                state <= FLG;
                            end
                            default: begin
                                done  <= 1'b1;
                                err   <= 1'b1;
                                state <= FLG;
                            end
                        endcase
                    end
                end
                EX1: begin
                    if (is_arith(cur_op)) begin
                        Eu    <= 1'b1;
                        nLa   <= 1'b0;
                        sub   <= (cur_op == OP_SUB);
                        state <= EX2;
                    end else begin
                        done  <= 1'b1;
                        state <= FLG;
                    end
                end
                EX2: begin
                    done  <= 1'b1;
                    state <= FLG;
                end
                FLG: begin
                    op_count <= op_count + 8'd1;
                    if (is_arith(cur_op)) begin
                        cf_q <= cf_in;
                        zf_q <= zf_in;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer; the FIFO scenario is compiled in when SEQ_FIFO_EN is defined.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [7:0] operand = 8'h00;
    logic       cf_in = 1'b0;
    logic       zf_in = 1'b0;
    logic       op_ready;
    logic [7:0] bus_data;
    logic       nLa, nLb, Ea, Eu, sub, out_sel;
    logic       cf_q, zf_q, done, err;
    logic [7:0] op_count;
    logic [5:0] ctl;

    int checks = 0;
    int failures = 0;

`ifdef SEQ_FIFO_EN
    localparam int   DEQ_LAT  = 1;
    localparam logic RDY_BUSY = 1'b1;
`else
    localparam int   DEQ_LAT  = 0;
    localparam logic RDY_BUSY = 1'b0;
`endif

    localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, ADD = 3'b010, SUB = 3'b011, OUT = 3'b100;

    // Control word {nLa, nLb, Ea, Eu, sub, out_sel}
    localparam logic [5:0] C_IDLE = 6'b110000;
    localparam logic [5:0] C_LDA  = 6'b010000;
    localparam logic [5:0] C_LDB  = 6'b100000;
    localparam logic [5:0] C_ADD  = 6'b010100;
    localparam logic [5:0] C_SUB  = 6'b010110;
    localparam logic [5:0] C_OUT  = 6'b111001;

    assign ctl = {nLa, nLb, Ea, Eu, sub, out_sel};

    alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .operand(operand), .bus_data(bus_data),
        .nLa(nLa), .nLb(nLb), .Ea(Ea), .Eu(Eu), .sub(sub), .out_sel(out_sel),
        .cf_in(cf_in), .zf_in(zf_in), .cf_q(cf_q), .zf_q(zf_q),
        .done(done), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits (bounded) for op_ready, then presents one pair for exactly one rising edge
    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: op_ready=%b required 1 within 50 cycles", op_ready);
        end
        op_valid = 1'b1;
        opcode   = op;
        operand  = d;
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_data !== 8'h00) begin failures++; $display("FAIL reset_bus: got %h want 00", bus_data); end
        checks++;
        if (ctl !== C_IDLE) begin failures++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE); end
        checks++;
        if ({cf_q, zf_q, done, err} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b want 0000", {cf_q, zf_q, done, err});
        end
        checks++;
        if (op_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", op_count); end
        checks++;
        if (op_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_rst: got %b want 0", op_ready); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after: got %b want 1", op_ready); end
    endtask

    task automatic test_lda();
        send(LDA, 8'h2A);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if (bus_data !== 8'h2A) begin failures++; $display("FAIL lda_bus: got %h want 2a", bus_data); end
        checks++;
        if (ctl !== C_LDA) begin failures++; $display("FAIL lda_ctl: got %b want %b", ctl, C_LDA); end
        @(negedge clk);
        checks++;
        if ({done, ctl} !== {1'b1, C_IDLE}) begin
            failures++; $display("FAIL lda_flg: got done=%b ctl=%b want done=1 ctl=%b", done, ctl, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if ({done, op_count, cf_q, zf_q} !== {1'b0, 8'd1, 2'b00}) begin
            failures++; $display("FAIL lda_after: got done=%b count=%0d cf=%b zf=%b want 0 1 0 0", done, op_count, cf_q, zf_q);
        end
    endtask

    task automatic test_add();
        cf_in = 1'b0;
        zf_in = 1'b0;
        send(ADD, 8'h05);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if ({ctl, bus_data} !== {C_LDB, 8'h05}) begin
            failures++; $display("FAIL add_ex1: got ctl=%b bus=%h want ctl=%b bus=05", ctl, bus_data, C_LDB);
        end
        checks++;
        if (op_ready !== RDY_BUSY) begin failures++; $display("FAIL add_ready_busy: got %b want %b", op_ready, RDY_BUSY); end
        @(negedge clk);
        checks++;
        if (ctl !== C_ADD) begin failures++; $display("FAIL add_ex2: got %b want %b", ctl, C_ADD); end
        @(negedge clk);
        checks++;
        if ({done, ctl} !== {1'b1, C_IDLE}) begin
            failures++; $display("FAIL add_flg: got done=%b ctl=%b want done=1 ctl=%b", done, ctl, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if ({cf_q, zf_q, op_count} !== {2'b00, 8'd2}) begin
            failures++; $display("FAIL add_after: got cf=%b zf=%b count=%0d want 0 0 2", cf_q, zf_q, op_count);
        end
    endtask

    task automatic test_sub_flags();
        cf_in = 1'b1;
        zf_in = 1'b1;
        send(SUB, 8'h2F);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if ({ctl, bus_data} !== {C_LDB, 8'h2F}) begin
            failures++; $display("FAIL sub_ex1: got ctl=%b bus=%h want ctl=%b bus=2f", ctl, bus_data, C_LDB);
        end
        @(negedge clk);
        checks++;
        if (ctl !== C_SUB) begin failures++; $display("FAIL sub_ex2: got %b want %b", ctl, C_SUB); end
        repeat (2) @(negedge clk);
        checks++;
        if ({cf_q, zf_q, op_count} !== {2'b11, 8'd3}) begin
            failures++; $display("FAIL sub_flags: got cf=%b zf=%b count=%0d want 1 1 3", cf_q, zf_q, op_count);
        end
        cf_in = 1'b0;
        zf_in = 1'b0;
        send(LDA, 8'h11);
        repeat (DEQ_LAT + 3) @(negedge clk);
        checks++;
        if ({cf_q, zf_q, op_count} !== {2'b11, 8'd4}) begin
            failures++; $display("FAIL lda_keeps_flags: got cf=%b zf=%b count=%0d want 1 1 4", cf_q, zf_q, op_count);
        end
    endtask

    task automatic test_illegal_out();
        send(3'b110, 8'h99);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if ({done, err, ctl, bus_data} !== {1'b1, 1'b1, C_IDLE, 8'h11}) begin
            failures++;
            $display("FAIL illegal_flg: got done=%b err=%b ctl=%b bus=%h want 1 1 %b 11", done, err, ctl, bus_data, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if ({done, op_count} !== {1'b0, 8'd5}) begin
            failures++; $display("FAIL illegal_after: got done=%b count=%0d want 0 5", done, op_count);
        end
        send(OUT, 8'h00);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if ({ctl, bus_data} !== {C_OUT, 8'h11}) begin
            failures++; $display("FAIL out_ex1: got ctl=%b bus=%h want ctl=%b bus=11", ctl, bus_data, C_OUT);
        end
        @(negedge clk);
        checks++;
        if ({done, ctl} !== {1'b1, C_IDLE}) begin
            failures++; $display("FAIL out_flg: got done=%b ctl=%b want done=1 ctl=%b", done, ctl, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if ({err, op_count} !== {1'b1, 8'd6}) begin
            failures++; $display("FAIL out_after: got err=%b count=%0d want 1 6", err, op_count);
        end
    endtask

    task automatic test_nop();
        send(NOP, 8'hFF);
        repeat (DEQ_LAT + 1) @(negedge clk);
        checks++;
        if ({done, ctl, bus_data} !== {1'b1, C_IDLE, 8'h11}) begin
            failures++; $display("FAIL nop_flg: got done=%b ctl=%b bus=%h want 1 %b 11", done, ctl, bus_data, C_IDLE);
        end
        @(negedge clk);
        checks++;
        if ({done, op_count, cf_q, zf_q} !== {1'b0, 8'd7, 2'b11}) begin
            failures++; $display("FAIL nop_after: got done=%b count=%0d cf=%b zf=%b want 0 7 1 1", done, op_count, cf_q, zf_q);
        end
    endtask

    task automatic test_reset_midop();
        int bad;
        send(ADD, 8'h33);
        repeat (DEQ_LAT + 1) @(negedge clk);
`ifdef SEQ_FIFO_EN
        op_valid = 1'b1;
        opcode   = LDA;
        operand  = 8'h77;
        @(posedge clk);
        #1 op_valid = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (ctl !== C_ADD) begin failures++; $display("FAIL rstmid_ex2: got %b want %b", ctl, C_ADD); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctl, bus_data, done, cf_q, zf_q} !== {C_IDLE, 8'h00, 3'b000}) begin
            failures++;
            $display("FAIL rstmid_outputs: got ctl=%b bus=%h done=%b cf=%b zf=%b want %b 00 0 0 0", ctl, bus_data, done, cf_q, zf_q, C_IDLE);
        end
        checks++;
        if ({err, op_count, op_ready} !== {1'b0, 8'd0, 1'b0}) begin
            failures++; $display("FAIL rstmid_state: got err=%b count=%0d ready=%b want 0 0 0", err, op_count, op_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b want 1", op_ready); end
        bad = 0;
        repeat (6) begin
            if (done !== 1'b0 || ctl !== C_IDLE) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || op_count !== 8'd0) begin
            failures++; $display("FAIL rstmid_dropped: got %0d active cycles count=%0d want 0 0", bad, op_count);
        end
    endtask

`ifdef SEQ_FIFO_EN
    task automatic test_fifo();
        int n;
        logic [2:0] f_op [5];
        logic [7:0] f_d [5];
        logic [5:0] x_ctl [6];
        logic [7:0] x_bus [6];
        f_op = '{ADD, SUB, LDA, OUT, NOP};
        f_d  = '{8'h02, 8'h03, 8'h01, 8'h00, 8'h00};
        x_ctl = '{C_LDB, C_ADD, C_LDB, C_SUB, C_LDA, C_OUT};
        x_bus = '{8'h02, 8'h02, 8'h03, 8'h03, 8'h01, 8'h01};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 254; i++) send(NOP, 8'h00);
        n = 0;
        while (op_count !== 8'd254 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (op_count !== 8'd254) begin failures++; $display("FAIL fifo_preset: got %0d want 254", op_count); end
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (op_ready !== 1'b1) begin failures++; $display("FAIL fifo_ready_push%0d: got %b want 1", i, op_ready); end
                    op_valid = 1'b1;
                    opcode   = f_op[i];
                    operand  = f_d[i];
                    @(negedge clk);
                end
                op_valid = 1'b0;
                checks++;
                if (op_ready !== 1'b0) begin failures++; $display("FAIL fifo_full: got op_ready=%b want 0", op_ready); end
            end
            begin
                int dn, k, cyc;
                dn = 0; k = 0; cyc = 0;
                while (dn < 5 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (done === 1'b1) dn++;
                    if (ctl !== C_IDLE) begin
                        if (k < 6) begin
                            checks++;
                            if ({ctl, bus_data} !== {x_ctl[k], x_bus[k]}) begin
                                failures++;
                                $display("FAIL fifo_order%0d: got ctl=%b bus=%h want ctl=%b bus=%h", k, ctl, bus_data, x_ctl[k], x_bus[k]);
                            end
                        end
                        k++;
                    end
                end
                checks++;
                if (dn != 5 || k != 6) begin
                    failures++; $display("FAIL fifo_done_count: got done=%0d strobes=%0d want 5 6", dn, k);
                end
            end
        join
        @(negedge clk);
        checks++;
        if (op_count !== 8'd3) begin failures++; $display("FAIL fifo_wrap: got %0d want 3", op_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_lda();
        test_add();
        test_sub_flags();
        test_illegal_out();
        test_nop();
        test_reset_midop();
`ifdef SEQ_FIFO_EN
        test_fifo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer that sits directly upstream of the 8-bit adder/accumulator datapath. It accepts (opcode, operand) pairs over a valid/ready handshake. It expands each one into a per-cycle control word: bus data, load/enable strobes and subtract select. It latches the carry and zero flags the datapath returns. This replaces hand-driving the control pins cycle by cycle.

## Interface
Parameters:
- FIFO_DEPTH, 4: entries in the optional input FIFO; power of two, 2..8; ignored when SEQ_FIFO_EN is undefined.

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  opcode/operand pair is present
- op_ready  out  1  block can accept a pair this cycle
- opcode  in  3  instruction: 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 OUT, 101/11x illegal
- operand  in  8  immediate data
- bus_data  out  8  value driven onto the datapath input bus
- nLa  out  1  accumulator load, active-low
- nLb  out  1  B-register load, active-low
- Ea  out  1  accumulator-to-bus enable
- Eu  out  1  ALU-to-bus enable
- sub  out  1  ALU subtract select
- out_sel  out  1  output mux select: 1 = bus, 0 = accumulator
- cf_in, zf_in  in  1 each  carry and zero flags from the ALU
- cf_q, zf_q  out  1 each  latched flags
- done  out  1  one-cycle pulse when an instruction completes
- err  out  1  sticky illegal-opcode flag
- op_count  out  8  completed-instruction counter

## Operation
- All outputs are registered.
- Reset values:
  - bus_data = 0x00, nLa = 1, nLb = 1, Ea = 0, Eu = 0, sub = 0, out_sel = 0
  - cf_q = 0, zf_q = 0, done = 0, err = 0, op_count = 0
  - state = IDLE, FIFO empty
- States: IDLE, EX1, EX2, FLG.
- Outside the listed cycles, every control output holds its idle value: nLa = nLb = 1, Ea = Eu = sub = out_sel = 0.
- Transfer occurs when op_valid and op_ready are both high. Only IDLE dequeues a pair into the current-instruction register (cur_op, cur_data).
- NOP: IDLE → FLG; no strobes.
- LDA:
  - EX1: bus_data = operand, nLa = 0.
  - Then FLG.
- ADD/SUB:
  - EX1: bus_data = operand, nLb = 0.
  - EX2: Eu = 1, nLa = 0, sub = (opcode == SUB).
  - FLG: cf_q/zf_q are loaded from cf_in/zf_in at the end of FLG.
- OUT:
  - EX1: Ea = 1, out_sel = 1.
  - Then FLG.
- Illegal opcode: executes as NOP and sets err = 1. err is cleared only by rst.
- FLG:
  - done = 1 for exactly this cycle.
  - op_count increments modulo 256; 255 wraps to 0.
  - Returns to IDLE.
- Flags update only on ADD/SUB. LDA, OUT, NOP and illegal opcodes leave cf_q/zf_q unchanged.
- bus_data holds its last value when not in use. No tristate anywhere in this block.

## Timing
- Handshake accepted at edge k; IDLE dequeues it (at edge k+1 with SEQ_FIFO_EN).
- First execute cycle follows the dequeue edge by one cycle.
- ADD/SUB occupy 3 cycles after IDLE (EX1, EX2, FLG).
- LDA and OUT occupy 2 cycles (EX1, FLG). NOP and illegal opcodes occupy 1 cycle (FLG).
- One IDLE cycle always separates consecutive instructions.
- EX2 follows EX1 by exactly one cycle. This matches the one-cycle bus input buffer in the datapath.
- rst asserted in any state: all outputs return to reset values at that edge, the in-flight instruction is dropped, and the FIFO is flushed. op_ready = 0 during the rst cycle.
- op_valid is ignored while op_ready = 0. The upstream source must hold opcode/operand stable until transfer.

## Configuration
- SEQ_FIFO_EN defined:
  - FIFO_DEPTH-entry FIFO in front of the sequencer.
  - op_ready = !full.
  - Simultaneous push and pop at full is not allowed, because ready is already low.
  - Simultaneous push and pop at a count of 1 keeps count 1.
- SEQ_FIFO_EN undefined:
  - Single holding register.
  - op_ready = 1 only in IDLE with the register empty.
  - Transfer and dequeue occur in the same cycle, so first-execute latency is one cycle shorter.

## Test plan
- Reset, then LDA 0x2A:
  - One cycle with bus_data = 0x2A and nLa = 0.
  - done pulses once; op_count = 1; cf_q = zf_q = 0.
- ADD 0x05 with cf_in = 0, zf_in = 0 during FLG:
  - EX1 shows nLb = 0 and bus_data = 0x05.
  - EX2 shows Eu = 1, nLa = 0, sub = 0.
  - After FLG, cf_q = 0 and zf_q = 0.
- SUB 0x2F with cf_in = 1, zf_in = 1 during FLG:
  - EX2 shows sub = 1.
  - After FLG, cf_q = 1 and zf_q = 1.
  - A following LDA leaves cf_q/zf_q at 1.
- Opcode 110, then OUT:
  - err = 1, no strobes for the illegal opcode, done pulses.
  - OUT shows Ea = 1 and out_sel = 1 for one cycle.
  - err stays 1.
- With SEQ_FIFO_EN, push 5 ops back-to-back while the first is executing:
  - op_ready drops after 4 are buffered.
  - All 5 complete in order with 5 done pulses.
  - Preset op_count = 254 via 254 NOPs first to check the wrap to 3.
- Assert rst during EX2 of an ADD:
  - All outputs take reset values at that edge; no done pulse.
  - FIFO is empty and op_ready = 1 in the cycle after rst deasserts.
